// File: rtl/simeck_round_ctrl.sv
// simeck_round_ctrl
// -----------------
// Sequencing controller for the iterative Simeck32/64 datapath. It holds no
// datapath of its own. It produces every load/enable strobe for the state
// register, the key register and the round-key store. The sequence is:
//   IDLE -> LOAD (1 cycle) -> KEYEXP (ROUNDS cycles, fills key store)
//        -> RUN (ROUNDS cycles, ascending keys for encrypt, descending for
//           decrypt) -> DONE (result held until accepted) -> IDLE
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   start, mode     operation request and direction (0 enc, 1 dec), sampled in IDLE
//   start_ack       IDLE & start (accept strobe)
//   busy            any state other than IDLE
//   ld_key/ld_state LOAD-cycle strobes for key and state registers
//   key_step        advance key register one schedule round (KEYEXP)
//   ks_we, ks_addr  key-store write enable and shared read/write address
//   z_bit           round-constant bit, valid only in KEYEXP
//   rnd_en          one round update of the state register (RUN)
//   out_valid       result valid (DONE)
//   out_ready       downstream accept
//   mode_q          captured direction, used by the datapath for word swap
//   dbg_state, dbg_cnt, dbg_lfsr   internal FSM state, counter and LFSR
//
// Result handshake: out_valid is high in DONE and stays high until out_ready
// is sampled high on a clock edge. That edge completes the transfer, and
// out_valid and busy are low after it. If out_ready is already high when DONE
// is entered, out_valid lasts exactly one cycle. A new start can be accepted
// no earlier than the cycle after the transfer edge.
module simeck_round_ctrl #(
    parameter int ROUNDS = 32,
    parameter int CNTW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode,
    output logic            start_ack,
    output logic            busy,
    output logic            ld_key,
    output logic            key_step,
    output logic            ks_we,
    output logic [CNTW-1:0] ks_addr,
    output logic            z_bit,
    output logic            ld_state,
    output logic            rnd_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            mode_q,
    output logic [2:0]      dbg_state,
    output logic [CNTW-1:0] dbg_cnt,
    output logic [4:0]      dbg_lfsr
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_KEYEXP = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Terminal count. The compare is against ROUNDS-1 and never depends on
    // the counter wrapping to 0.
    localparam logic [CNTW-1:0] LAST     = CNTW'(ROUNDS - 1);
    localparam logic [4:0]      LFSR_INI = 5'b11111;

    logic [2:0]      state;
    logic [CNTW-1:0] cnt;
    logic [4:0]      lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            lfsr   <= LFSR_INI;
            mode_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_LOAD;
                        mode_q <= mode;
                    end
                end
                S_LOAD: begin
                    cnt   <= '0;
                    lfsr  <= LFSR_INI;
                    state <= S_KEYEXP;
                end
                S_KEYEXP: begin
                    // The LFSR advances only here, so z_bit tracks the
                    // key-schedule step index.
                    lfsr <= {lfsr[0] ^ lfsr[2], lfsr[4:1]};
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                S_RUN: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // All outputs are decodes of registered state. The only exception is
    // start_ack, which also looks at the start input.
    assign start_ack = (state == S_IDLE) && start;
    assign busy      = (state != S_IDLE);
    assign ld_key    = (state == S_LOAD);
    assign ld_state  = (state == S_LOAD);
    assign key_step  = (state == S_KEYEXP);
    assign ks_we     = (state == S_KEYEXP);
    assign rnd_en    = (state == S_RUN);
    assign out_valid = (state == S_DONE);
    assign z_bit     = (state == S_KEYEXP) && lfsr[0];

    // Decrypt walks the key store from the top. LAST - cnt cannot underflow
    // because cnt never exceeds LAST.
    always_comb begin
        ks_addr = '0;
        if (state == S_KEYEXP) begin
            ks_addr = cnt;
        end else if (state == S_RUN) begin
            ks_addr = mode_q ? (LAST - cnt) : cnt;
        end
    end

    assign dbg_state = state;
    assign dbg_cnt   = cnt;
    assign dbg_lfsr  = lfsr;

endmodule
